// File: rtl/mem_ctrl.sv
// MEM-stage load/store sequencer onto a single wait-stated data bus (IDLE -> BUS -> DONE).
// Optional macro MEM_CTRL_ALIGN_CHECK_EN rejects misaligned accesses and adds addr_err_o.
module mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_sign_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              flush_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  output logic              addr_err_o,
`endif
  input  logic [31:0]       bus_rdata_i
);

  localparam int TMR_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TMO_CYC);
  localparam bit TMO_EN = (TMO_CYC > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                abort_q, abort_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [1:0]          off_q, off_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_sel_q, bus_sel_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fault_s;
  logic [1:0]          off_s;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_sel = 4'b1000 >> off;
      2'b01:   lane_sel = off[1] ? 4'b0011 : 4'b1100;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Lane 0 is the most significant byte of the bus word (big-endian).
  function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] off,
                                             input logic sign, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (size)
      2'b00:   load_align = {{24{sign & b[7]}}, b};
      2'b01:   load_align = {{16{sign & h[15]}}, h};
      default: load_align = d;
    endcase
  endfunction

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic misalign_s;
  assign misalign_s = ((mem_size_i == 2'b01) & mem_addr_i[0]) |
                      (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00));
  assign fault_s    = misalign_s;
  assign addr_err_o = mem_req_i & fault_s & (state_q == ST_IDLE);
`else
  assign fault_s = 1'b0;
`endif

  assign stallreq_o = mem_req_i & ~flush_i & (state_q != ST_DONE) & ~fault_s;

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

  // Natural alignment: half drops bit 0, word drops both offset bits.
  always_comb begin
    off_s = mem_addr_i[1:0];
    case (mem_size_i)
      2'b00:   off_s = mem_addr_i[1:0];
      2'b01:   off_s = {mem_addr_i[1], 1'b0};
      default: off_s = 2'b00;
    endcase
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    timer_d     = timer_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i & ~flush_i & ~fault_s) begin
          state_d     = ST_BUS;
          abort_d     = 1'b0;
          timer_d     = '0;
          size_d      = mem_size_i;
          sign_d      = mem_sign_i;
          off_d       = off_s;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          bus_sel_d   = lane_sel(mem_size_i, off_s);
          bus_wdata_d = lane_wdata(mem_size_i, mem_wdata_i);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        timer_d = timer_q + TMR_W'(1);
        abort_d = abort_q | flush_i;
        // A flushed access still finishes on the bus, but reports nothing.
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (abort_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = load_align(size_q, off_q, sign_q, bus_rdata_i);
          end
        end else if (TMO_EN && (timer_d == TMO_V)) begin
          bus_req_d = 1'b0;
          if (abort_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      abort_q     <= 1'b0;
      timer_q     <= '0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      timer_q     <= timer_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed and random accesses against a lane/latency model.
module tb_mem_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, mem_sign_i, flush_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, stallreq_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic        addr_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_sign_i(mem_sign_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i),
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    .addr_err_o(addr_err_o),
`endif
    .bus_rdata_i(bus_rdata_i)
  );

  task automatic idle_inputs();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_sign_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0; flush_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
  endtask

  // Reference: byte offset after natural alignment for the access size.
  function automatic int eff_off(input logic [1:0] size, input logic [31:0] addr);
    int o;
    o = int'(addr[1:0]);
    if (size == 2'b01) o = o & 2;
    else if (size[1]) o = 0;
    return o;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] size, input int o);
    if (size == 2'b00) return 4'(1 << (3 - o));
    if (size == 2'b01) return (o == 0) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input int o, input logic sign,
                                           input logic [31:0] rd);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rd >> (8 * (3 - o))) & 32'hFF;
      if (sign && v >= 32'd128) v = v - 32'd256;
      return v;
    end
    if (size == 2'b01) begin
      v = (rd >> (16 * (1 - o / 2))) & 32'hFFFF;
      if (sign && v >= 32'd32768) v = v - 32'd65536;
      return v;
    end
    return rd;
  endfunction

  // One complete access; the bus answers after 'waits' wait cycles (or never, if >= TMO).
  task automatic run_access(input string name, input logic we, input logic [1:0] size,
                            input logic sign, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits);
    int o, nb, nstall, exp_bus, done_c;
    bit acked;
    logic [31:0] e_rd;
    o = eff_off(size, addr);
    acked = (waits + 1 <= TMO);
    exp_bus = acked ? waits + 1 : TMO;
    e_rd = acked ? exp_load(size, o, sign, rd) : 32'h0;
    nb = 0; nstall = 0; done_c = -1;
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_sign_i = sign;
    mem_addr_i = addr; mem_wdata_i = wd;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
      if (bus_req_o) begin
        if (nb == 0) begin
          n_checks++;
          if (bus_addr_o !== (addr & 32'hFFFF_FFFC) || bus_sel_o !== exp_sel(size, o) ||
              bus_we_o !== we || (we && bus_wdata_o !== exp_wdata(size, wd))) begin
            n_fail++;
            $display("FAIL %s bus: addr %h sel %b we %b wd %h, need addr %h sel %b we %b wd %h",
                     name, bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o, addr & 32'hFFFF_FFFC,
                     exp_sel(size, o), we, exp_wdata(size, wd));
          end
        end
        if (nb == waits) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = rd;
        end
        nb++;
      end
      #1;
      if (done_o) begin
        done_c = c;
        n_checks++;
        if (stallreq_o !== 1'b0) begin
          n_fail++; $display("FAIL %s stall_in_done: got %b need 0", name, stallreq_o);
        end
      end else if (stallreq_o) begin
        nstall++;
      end
      if (done_c < 0) @(negedge clk);
    end
    n_checks++;
    if (done_c != exp_bus + 1) begin
      n_fail++; $display("FAIL %s latency: done at cycle %0d need %0d", name, done_c, exp_bus + 1);
    end
    n_checks++;
    if (nb != exp_bus || nstall != exp_bus + 1) begin
      n_fail++; $display("FAIL %s cycles: bus_req %0d stall %0d, need %0d / %0d",
                         name, nb, nstall, exp_bus, exp_bus + 1);
    end
    n_checks++;
    if (err_o !== !acked || (!we && rdata_o !== e_rd) || (!acked && rdata_o !== 32'h0)) begin
      n_fail++; $display("FAIL %s result: rdata %h err %b need rdata %h err %b",
                         name, rdata_o, err_o, e_rd, !acked);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (done_o !== 1'b0 || bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done: done %b bus_req %b need 0 0", name, done_o, bus_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req_o, done_o, err_o, bus_we_o, stallreq_o} !== 5'b0 || rdata_o !== 32'h0 ||
        bus_addr_o !== 32'h0 || bus_sel_o !== 4'h0 || bus_wdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_state: req %b done %b err %b we %b stall %b rd %h addr %h sel %b wd %h need all 0",
                         bus_req_o, done_o, err_o, bus_we_o, stallreq_o, rdata_o, bus_addr_o, bus_sel_o, bus_wdata_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h40;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_start: bus_req %b need 1", bus_req_o);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_drop: bus_req %b need 0", bus_req_o);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: bus_req %b done %b need 0 0", bus_req_o, done_o);
    end
  endtask

  task automatic test_ignored_inputs();
    mem_req_i = 1'b1; flush_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h80;
    #1;
    n_checks++;
    if (stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_stall: got %b need 0", stallreq_o);
    end
    @(negedge clk);
    idle_inputs();
    bus_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: bus_req %b done %b need 0 0", bus_req_o, done_o);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_access("lw_0x100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1122_3344, 0);
    run_access("lb_0x103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_00F0, 3);
    run_access("sh_0x202", 1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD_1234, 32'h0, 1);
    run_access("lh_sign",  1'b0, 2'b01, 1'b1, 32'h204, 32'h0, 32'h8001_7FFF, 2);
    run_access("size_11",  1'b0, 2'b11, 1'b0, 32'h208, 32'h0, 32'hDEAD_BEEF, 0);
    run_access("timeout",  1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, 99);
  endtask

  task automatic test_misaligned();
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h102;
    #1;
    n_checks++;
    if (addr_err_o !== 1'b1 || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_err: addr_err %b stall %b need 1 0", addr_err_o, stallreq_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_nobus: bus_req %b need 0", bus_req_o);
    end
    idle_inputs();
    @(negedge clk);
`else
    run_access("lw_0x102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hCAFE_F00D, 0);
    run_access("lh_0x101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'hCAFE_F00D, 1);
`endif
  endtask

  // Flush in the 2nd BUS cycle; a new lw waits behind the abandoned access.
  task automatic test_flush();
    int wa, wb, nb, txn, dones, done_c, exp_c;
    bit prev;
    logic [31:0] rd_b;
    wa = $urandom_range(1, 3); wb = $urandom_range(0, 2);
    rd_b = $urandom;
    exp_c = wa + wb + 4;
    nb = 0; txn = -1; dones = 0; done_c = -1; prev = 1'b0;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      if (c == 0) begin
        mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h500;
      end else if (c == 2) begin
        mem_req_i = 1'b0; flush_i = 1'b1;
      end else if (c == 3) begin
        flush_i = 1'b0; mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h604;
      end
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0BAD_0BAD;
      if (bus_req_o) begin
        if (!prev) begin txn++; nb = 0; end
        if (txn == 1 && nb == 0) begin
          n_checks++;
          if (bus_addr_o !== 32'h604) begin
            n_fail++; $display("FAIL flush_2nd_addr: got %h need 00000604", bus_addr_o);
          end
        end
        if (nb == ((txn == 0) ? wa : wb)) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = (txn == 0) ? 32'h0BAD_0BAD : rd_b;
        end
        nb++;
      end
      prev = bus_req_o;
      #1;
      if (done_o) begin
        dones++; done_c = c;
      end else if (c >= 3) begin
        n_checks++;
        if (stallreq_o !== 1'b1) begin
          n_fail++; $display("FAIL flush_stall c%0d: got %b need 1", c, stallreq_o);
        end
      end else begin
        // first three cycles: no stall only while the flush is asserted
      end
      if (done_c < 0) @(negedge clk);
    end
    n_checks++;
    if (dones != 1 || done_c != exp_c || txn != 1 || rdata_o !== rd_b) begin
      n_fail++; $display("FAIL flush_result: dones %0d at %0d txn %0d rdata %h, need 1 at %0d txn 1 rdata %h",
                         dones, done_c, txn, rdata_o, exp_c, rd_b);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      if (size == 2'b01) addr[0] = 1'b0;
      else if (size[1]) addr[1:0] = 2'b00;
      else addr[1:0] = addr[1:0];
`endif
      run_access("random", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                 addr, $urandom, $urandom, $urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_inputs();
    test_misaligned();
    test_flush();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
